// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
//   Bundles the requester byte-stream handshake and the UART bus-slave write
//   port that the arbiter sits between.
//   Requester side : req_valid/req_data/req_last in, req_ready/grant out.
//   UART side      : uart_addr/uart_data_write/uart_uds/uart_lds/uart_rw out,
//                    uart_ack in.
//   slave  - the arbiter's view.
//   master - the surrounding system (requesters plus UART) driving the arbiter.
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0][7:0] req_data;   // byte of requester i at [8i+7:8i]
  logic [NREQ-1:0]      req_last;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      grant;
  logic [7:0]           uart_addr;
  logic [15:0]          uart_data_write;
  logic                 uart_uds;
  logic                 uart_lds;
  logic                 uart_rw;
  logic                 uart_ack;

  modport slave (
    input  req_valid, req_data, req_last, uart_ack,
    output req_ready, grant, uart_addr, uart_data_write, uart_uds, uart_lds, uart_rw
  );

  modport master (
    output req_valid, req_data, req_last, uart_ack,
    input  req_ready, grant, uart_addr, uart_data_write, uart_uds, uart_lds, uart_rw
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one UART transmitter between NREQ byte-stream requesters. Grants
//   round-robin, keeps the grant for a whole packet (until req_last), performs
//   the UART TX-data-register write cycle and waits for the UART ack.
// Ports
//   i_clk          system clock
//   i_reset        asynchronous, active-high reset
//   bus            uart_tx_arbiter_if.slave (requester handshake + UART bus)
//   o_busy         FSM not idle, or a packet lock is held
//   o_err_timeout  1-cycle pulse on ack timeout or lock timeout
// All outputs are registered. The idle bus is a read of unmapped address
// 8'hFF with no strobes, which the UART ignores.
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
  parameter int         NREQ         = 4,
  parameter logic [7:0] UART_ADDR    = 8'h03,
  parameter int         ACK_TIMEOUT  = 65535,
  parameter int         LOCK_TIMEOUT = 4095
) (
  input  logic             i_clk,
  input  logic             i_reset,
  uart_tx_arbiter_if.slave bus,
  output logic             o_busy,
  output logic             o_err_timeout
);

  localparam int          IW       = $clog2(NREQ);
  localparam logic [15:0] ACK_LIM  = 16'(ACK_TIMEOUT - 1);
  localparam logic [15:0] LOCK_LIM = 16'(LOCK_TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_WRITE} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_lock, w_lock_nxt;
  logic [IW-1:0]   r_rr, r_owner;
  logic            r_last;
  logic [15:0]     r_ack_cnt, r_lock_cnt;

  logic [NREQ-1:0] r_req_ready, r_grant;
  logic [7:0]      r_addr;
  logic [15:0]     r_dw;
  logic            r_lds, r_rw, r_busy, r_err;

  logic [NREQ-1:0] w_req_ready_nxt, w_grant_nxt;
  logic [7:0]      w_addr_nxt;
  logic [15:0]     w_dw_nxt;
  logic            w_lds_nxt, w_rw_nxt, w_busy_nxt, w_err_nxt;

  logic [NREQ-1:0] w_owner_oh, w_cand;
  logic [IW-1:0]   w_pick;
  logic            w_pick_vld, w_owner_idle, w_ack_to, w_lock_to, w_done;

  assign w_owner_oh   = NREQ'(1) << r_owner;
  // While locked only the packet owner may compete.
  assign w_cand       = r_lock ? (w_owner_oh & bus.req_valid) : bus.req_valid;
  assign w_owner_idle = r_lock && !(|(w_owner_oh & bus.req_valid));
  assign w_ack_to     = (r_state == S_WRITE) && !bus.uart_ack && (r_ack_cnt == ACK_LIM);
  assign w_lock_to    = (r_state == S_IDLE) && w_owner_idle && (r_lock_cnt == LOCK_LIM);
  assign w_done       = (r_state == S_WRITE) && (bus.uart_ack || w_ack_to);

  // Round-robin search starting at rr+1. Scanning from the far end down lets
  // the nearest candidate overwrite the others, so no priority flag is needed.
  always_comb begin
    int w_idx;
    w_pick_vld = 1'b0;
    w_pick     = '0;
    w_idx      = 0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = (int'(r_rr) + k) % NREQ;
      if (w_cand[IW'(w_idx)]) begin
        w_pick_vld = 1'b1;
        w_pick     = IW'(w_idx);
      end
    end
  end

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_lock  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_lock  <= w_lock_nxt;
    end
  end

  // Next state (FSM state plus packet lock)
  always_comb begin
    w_state_nxt = r_state;
    w_lock_nxt  = r_lock;
    case (r_state)
      S_IDLE: begin
        if (w_pick_vld) begin
          w_state_nxt = S_WRITE;
          if (!bus.req_last[w_pick]) w_lock_nxt = 1'b1;
        end else if (w_lock_to) begin
          w_lock_nxt = 1'b0;
        end
      end
      S_WRITE: begin
        if (bus.uart_ack) begin
          w_state_nxt = S_IDLE;
          if (r_last) w_lock_nxt = 1'b0;
        end else if (w_ack_to) begin
          // Dropped byte also abandons the packet.
          w_state_nxt = S_IDLE;
          w_lock_nxt  = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output next-values (registered below)
  always_comb begin
    w_req_ready_nxt = '0;
    w_grant_nxt     = r_grant;
    w_addr_nxt      = r_addr;
    w_dw_nxt        = r_dw;
    w_lds_nxt       = r_lds;
    w_rw_nxt        = r_rw;
    w_err_nxt       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pick_vld) begin
          w_req_ready_nxt = NREQ'(1) << w_pick;
          w_grant_nxt     = NREQ'(1) << w_pick;
          w_addr_nxt      = UART_ADDR;
          w_dw_nxt        = {8'h00, bus.req_data[w_pick]};
          w_lds_nxt       = 1'b1;
          w_rw_nxt        = 1'b0;
        end else if (w_lock_to) begin
          w_grant_nxt = '0;
          w_err_nxt   = 1'b1;
        end
      end
      S_WRITE: begin
        if (w_done) begin
          w_addr_nxt  = 8'hFF;
          w_dw_nxt    = '0;
          w_lds_nxt   = 1'b0;
          w_rw_nxt    = 1'b1;
          w_err_nxt   = w_ack_to;
          // Grant survives the ack only if the packet continues.
          w_grant_nxt = (bus.uart_ack && !r_last) ? r_grant : '0;
        end
      end
      default: ;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE) || w_lock_nxt;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_req_ready <= '0;
      r_grant     <= '0;
      r_addr      <= 8'hFF;
      r_dw        <= '0;
      r_lds       <= 1'b0;
      r_rw        <= 1'b1;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_req_ready <= w_req_ready_nxt;
      r_grant     <= w_grant_nxt;
      r_addr      <= w_addr_nxt;
      r_dw        <= w_dw_nxt;
      r_lds       <= w_lds_nxt;
      r_rw        <= w_rw_nxt;
      r_busy      <= w_busy_nxt;
      r_err       <= w_err_nxt;
    end
  end

  // Arbitration bookkeeping and timeout counters
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rr       <= IW'(NREQ - 1);
      r_owner    <= '0;
      r_last     <= 1'b0;
      r_ack_cnt  <= '0;
      r_lock_cnt <= '0;
    end else begin
      if (r_state == S_IDLE && w_pick_vld) begin
        r_rr      <= w_pick;
        r_owner   <= w_pick;
        r_last    <= bus.req_last[w_pick];
        r_ack_cnt <= '0;
      end else if (r_state == S_WRITE) begin
        r_ack_cnt <= r_ack_cnt + 16'd1;
      end
      // Counts consecutive idle cycles in which the lock owner has nothing.
      if (r_state == S_IDLE && w_owner_idle && !w_lock_to)
        r_lock_cnt <= r_lock_cnt + 16'd1;
      else
        r_lock_cnt <= '0;
    end
  end

  assign bus.req_ready       = r_req_ready;
  assign bus.grant           = r_grant;
  assign bus.uart_addr       = r_addr;
  assign bus.uart_data_write = r_dw;
  assign bus.uart_uds        = 1'b0;
  assign bus.uart_lds        = r_lds;
  assign bus.uart_rw         = r_rw;
  assign o_busy              = r_busy;
  assign o_err_timeout       = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  localparam int NREQ    = 4;
  localparam int ACK_TO  = 16;
  localparam int LOCK_TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, err;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus();

  uart_tx_arbiter #(
    .NREQ(NREQ), .UART_ADDR(8'h03), .ACK_TIMEOUT(ACK_TO), .LOCK_TIMEOUT(LOCK_TO)
  ) dut (
    .i_clk(clk), .i_reset(rst), .bus(bus), .o_busy(busy), .o_err_timeout(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Requester queues: {last, data}
  logic [8:0] rq [NREQ][$];
  logic [NREQ-1:0] en = '0;
  bit rnd = 0, no_ack = 0;

  // Reference model: transaction-level view of who owns the UART
  bit         m_write = 0, m_lock = 0, m_last = 0;
  int         m_rr = NREQ - 1, m_wr = 0, m_owner = 0, m_wcnt = 0, m_lcnt = 0, ack_dly = 0;
  logic [7:0] m_byte = '0;
  int         picks[$];
  logic [7:0] sent[$];
  int         n_sent[NREQ];
  int         n_push[NREQ];
  int         n_errp = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NREQ-1:0] oh(input int i);
    return NREQ'(1) << i;
  endfunction

  task automatic push(input int r, input logic [7:0] d, input logic l);
    rq[r].push_back({l, d});
    n_push[r]++;
  endtask

  // One clock: predict the effect of the last edge, compare, drive next inputs.
  task automatic tick();
    logic [NREQ-1:0] cand, exp_rdy, exp_gnt;
    logic exp_err, v;
    int w, j;
    @(negedge clk);
    exp_rdy = '0;
    exp_err = 1'b0;
    if (rst) begin
      m_write = 0; m_lock = 0; m_rr = NREQ - 1; m_lcnt = 0;
    end else if (!m_write) begin
      cand = m_lock ? (bus.req_valid & oh(m_owner)) : bus.req_valid;
      w = -1;
      for (int k = 1; k <= NREQ; k++) begin
        j = (m_rr + k) % NREQ;
        if (w < 0 && cand[j]) w = j;
      end
      if (w >= 0) begin
        {m_last, m_byte} = rq[w].pop_front();
        m_write = 1; m_wr = w; m_rr = w; m_wcnt = 0; m_lcnt = 0;
        if (!m_last) begin m_lock = 1; m_owner = w; end
        exp_rdy = oh(w);
        picks.push_back(w);
        ack_dly = $urandom_range(0, 5);
      end else if (m_lock && !bus.req_valid[m_owner]) begin
        m_lcnt++;
        if (m_lcnt == LOCK_TO) begin m_lock = 0; m_lcnt = 0; exp_err = 1; end
      end else begin
        m_lcnt = 0;
      end
    end else begin
      m_wcnt++;
      m_lcnt = 0;
      if (bus.uart_ack) begin
        m_write = 0;
        sent.push_back(m_byte);
        n_sent[m_wr]++;
        if (m_last) m_lock = 0;
      end else if (m_wcnt == ACK_TO) begin
        m_write = 0; m_lock = 0; exp_err = 1;
      end
    end

    exp_gnt = m_write ? oh(m_wr) : (m_lock ? oh(m_owner) : '0);
    chk("req_ready", bus.req_ready, exp_rdy);
    chk("grant", bus.grant, exp_gnt);
    chk("rw", bus.uart_rw, !m_write);
    chk("lds", bus.uart_lds, m_write);
    chk("uds", bus.uart_uds, 1'b0);
    chk("addr", bus.uart_addr, m_write ? 8'h03 : 8'hFF);
    if (m_write) chk("data", bus.uart_data_write, {8'h00, m_byte});
    chk("busy", busy, m_write || m_lock);
    chk("err_timeout", err, exp_err);
    if (err) n_errp++;

    for (int i = 0; i < NREQ; i++) begin
      v = en[i] && (rq[i].size() > 0) && (!rnd || $urandom_range(0, 3) != 0);
      bus.req_valid[i] = v;
      bus.req_data[i]  = v ? rq[i][0][7:0] : 8'($urandom);
      bus.req_last[i]  = v ? rq[i][0][8] : 1'($urandom);
    end
    bus.uart_ack = 1'b0;
    if (m_write && !no_ack) begin
      if (ack_dly == 0) bus.uart_ack = 1'b1;
      else ack_dly--;
    end
  endtask

  function automatic bit pending();
    bit p = m_write || m_lock;
    for (int i = 0; i < NREQ; i++) if (en[i] && rq[i].size() > 0) p = 1;
    return p;
  endfunction

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (pending() && n < budget) begin tick(); n++; end
    chk({tag, "_drain_bound"}, n < budget, 1'b1);
  endtask

  task automatic wait_picks(input string tag, input int cnt, input int budget);
    int n = 0;
    while (picks.size() < cnt && n < budget) begin tick(); n++; end
    chk({tag, "_pick_bound"}, n < budget, 1'b1);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.uart_ack  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin n_sent[i] = 0; n_push[i] = 0; end

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // Round robin from rr = NREQ-1, all single-byte packets
    en = '1;
    for (int r = 0; r < 3; r++) begin push(r, 8'h10 + 8'(r), 1); push(r, 8'h20 + 8'(r), 1); end
    drain("rr", 300);
    chk("rr_cnt", picks.size(), 6);
    for (int i = 0; i < 6 && i < picks.size(); i++) chk($sformatf("rr_order%0d", i), picks[i], i % 3);

    // Packet lock: req1 owns the UART for 31,32,33 while req0 waits
    picks.delete(); sent.delete();
    en = 4'b0010;
    push(1, 8'h31, 0); push(1, 8'h32, 0); push(1, 8'h33, 1); push(0, 8'h41, 1);
    wait_picks("lock", 1, 50);
    en = '1;
    drain("lock", 300);
    chk("lock_cnt", sent.size(), 4);
    for (int i = 0; i < 4 && i < sent.size(); i++) begin
      logic [31:0] exp_b [4];
      exp_b = '{32'h31, 32'h32, 32'h33, 32'h41};
      chk($sformatf("lock_seq%0d", i), sent[i], exp_b[i]);
    end

    // Ack timeout: UART never answers, the byte is dropped
    sent.delete(); n_errp = 0; no_ack = 1;
    push(2, 8'h77, 1);
    drain("ackto", 100);
    chk("ackto_pulses", n_errp, 1);
    chk("ackto_sent", sent.size(), 0);
    no_ack = 0;

    // Lock timeout: owner stalls mid-packet, req0 gets the UART afterwards
    picks.delete(); sent.delete(); n_errp = 0;
    en = 4'b1000;
    push(3, 8'h51, 0); push(3, 8'h52, 1);
    wait_picks("lockto", 1, 50);
    en = 4'b0001;
    push(0, 8'h61, 1);
    drain("lockto", 200);
    chk("lockto_pulses", n_errp, 1);
    en = '1;
    drain("lockto2", 200);
    chk("lockto_cnt", picks.size(), 3);
    if (picks.size() == 3) begin
      chk("lockto_p1", picks[1], 0);
      chk("lockto_p2", picks[2], 3);
    end

    // Randomized traffic
    for (int i = 0; i < NREQ; i++) begin n_sent[i] = 0; n_push[i] = 0; end
    for (int p = 0; p < 40; p++) begin
      int r, len;
      r = $urandom_range(0, NREQ - 1);
      len = $urandom_range(1, 3);
      for (int b = 0; b < len; b++) push(r, 8'($urandom), b == len - 1);
    end
    rnd = 1;
    drain("rand", 4000);
    rnd = 0;
    for (int i = 0; i < NREQ; i++) chk($sformatf("rand_bytes%0d", i), n_sent[i], n_push[i]);

    // Reset in the middle of a write
    sent.delete(); picks.delete();
    push(1, 8'h99, 1);
    wait_picks("rstw", 1, 50);
    #2 rst = 1'b1;
    #1;
    chk("rstw_rw", bus.uart_rw, 1'b1);
    chk("rstw_lds", bus.uart_lds, 1'b0);
    chk("rstw_addr", bus.uart_addr, 8'hFF);
    chk("rstw_grant", bus.grant, '0);
    chk("rstw_busy", busy, 1'b0);
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    m_write = 0; m_lock = 0; m_rr = NREQ - 1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("rstw_not_sent", sent.size(), 0);
    picks.delete();
    push(3, 8'hA3, 1); push(0, 8'hA0, 1);
    drain("rstw", 100);
    chk("rstw_cnt", sent.size(), 2);
    if (sent.size() == 2) begin
      chk("rstw_first", sent[0], 8'hA0);
      chk("rstw_second", sent[1], 8'hA3);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
